// File: rtl/ram_sp_mode.sv
// rtl/ram_sp_mode.sv - single-port byte-lane BRAM with selectable read-during-write mode and optional output register
// Optional power-up clear of the array is enabled by defining RAM_INIT_CLEAR_EN.
module ram_sp_mode #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int BYTE_W     = 8,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0,
  localparam int NUM_BYTES = WIDTH / BYTE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NUM_BYTES-1:0]  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      di,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             accept;
  logic             is_write;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged;

  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;

  logic             clr_we;
  logic [IDX_W-1:0] clr_cnt;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = 32'(addr) < DEPTH;
  assign is_write = |we;
  assign accept   = en && !busy && !rst;

  // Out-of-range addresses read as zero and never touch the array.
  assign old_word = in_range ? mem[idx] : '0;

  always_comb begin
    merged = old_word;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (we[b] && in_range) begin
        merged[b*BYTE_W +: BYTE_W] = di[b*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef RAM_INIT_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] clr_cnt_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    clr_cnt_n = clr_cnt;
    clr_we    = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (32'(clr_cnt) == DEPTH - 1) begin
          state_n   = IDLE;
          clr_cnt_n = '0;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state == CLEAR);
`else
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_cnt = '0;
`endif

  // Array write port: clear sweep or lane-masked user write, never while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem[clr_cnt] <= '0;
      end else if (accept && is_write && in_range) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (we[b]) begin
            mem[idx][b*BYTE_W +: BYTE_W] <= di[b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Stage 1: no-change mode keeps the previous word and raises no valid on writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept && !(is_write && READ_MODE == 2);
      if (accept) begin
        if (!is_write) begin
          s1_data <= old_word;
        end else if (READ_MODE == 0) begin
          s1_data <= merged;
        end else if (READ_MODE == 1) begin
          s1_data <= old_word;
        end
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_data  <= s1_data;
          s2_valid <= s1_valid;
        end
      end

      assign dout       = s2_data;
      assign dout_valid = s2_valid;
    end else begin : g_no_out_reg
      assign dout       = s1_data;
      assign dout_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_ram_sp_mode.sv
// tb/tb_ram_sp_mode.sv - directed vector bench for ram_sp_mode across read modes and output latency
// Clear-sweep checks are included when RAM_INIT_CLEAR_EN is defined.
module tb_ram_sp_mode;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  we;
  logic [4:0]  addr;
  logic [31:0] di;

  logic [31:0] d0, d1, d2, d3;
  logic        v0, v1, v2, v3;
  logic        b0, b1, b2, b3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_sp_mode #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5), .BYTE_W(8), .READ_MODE(0), .OUT_REG(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di),
    .dout(d0), .dout_valid(v0), .busy(b0));
  ram_sp_mode #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5), .BYTE_W(8), .READ_MODE(1), .OUT_REG(0)) u1 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di),
    .dout(d1), .dout_valid(v1), .busy(b1));
  ram_sp_mode #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5), .BYTE_W(8), .READ_MODE(2), .OUT_REG(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di),
    .dout(d2), .dout_valid(v2), .busy(b2));
  ram_sp_mode #(.WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(5), .BYTE_W(8), .READ_MODE(0), .OUT_REG(1)) u3 (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di),
    .dout(d3), .dout_valid(v3), .busy(b3));

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [4:0]  addr;
    logic [31:0] di;
    logic [31:0] d0; logic v0;
    logic [31:0] d1; logic v1; logic dc1;
    logic [31:0] d2; logic v2;
    logic [31:0] d3; logic v3;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic e, input logic [3:0] w, input logic [4:0] a, input logic [31:0] d,
                              input logic [31:0] x0, input logic y0,
                              input logic [31:0] x1, input logic y1, input logic dc,
                              input logic [31:0] x2, input logic y2,
                              input logic [31:0] x3, input logic y3);
    vec_t r;
    r.en = e; r.we = w; r.addr = a; r.di = d;
    r.d0 = x0; r.v0 = y0; r.d1 = x1; r.v1 = y1; r.dc1 = dc;
    r.d2 = x2; r.v2 = y2; r.d3 = x3; r.v3 = y3;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
`ifdef RAM_INIT_CLEAR_EN
    int n;
    n = 0;
    while (b0 && n < 200) begin
      step();
      n++;
    end
    chk("clear_cycles", 32'(n), 32'(DEPTH));
`else
    chk("busy_tied_low", {28'd0, b0, b1, b2, b3}, 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; we = 4'h0; addr = '0; di = '0;
    step();
    rst = 1'b0;
    chk("rst_d0", d0, 32'd0); chk("rst_d3", d3, 32'd0);
    chk("rst_valids", {28'd0, v0, v1, v2, v3}, 32'd0);
    wait_idle();
  endtask

  initial begin
    tbl[0]  = mk(1, 4'hF, 5,  32'hDEADBEEF, 32'hDEADBEEF,1, 32'h0,1,1,        32'h0,0,        32'h0,0);
    tbl[1]  = mk(1, 4'h0, 5,  32'h0,        32'hDEADBEEF,1, 32'hDEADBEEF,1,0, 32'hDEADBEEF,1, 32'hDEADBEEF,1);
    tbl[2]  = mk(1, 4'h5, 5,  32'h11223344, 32'hDE22BE44,1, 32'hDEADBEEF,1,0, 32'hDEADBEEF,0, 32'hDEADBEEF,1);
    tbl[3]  = mk(1, 4'h0, 5,  32'h0,        32'hDE22BE44,1, 32'hDE22BE44,1,0, 32'hDE22BE44,1, 32'hDE22BE44,1);
    tbl[4]  = mk(0, 4'hF, 5,  32'hFFFFFFFF, 32'hDE22BE44,0, 32'hDE22BE44,0,0, 32'hDE22BE44,0, 32'hDE22BE44,1);
    tbl[5]  = mk(1, 4'h0, 5,  32'h0,        32'hDE22BE44,1, 32'hDE22BE44,1,0, 32'hDE22BE44,1, 32'hDE22BE44,0);
    tbl[6]  = mk(1, 4'hF, 1,  32'h1,        32'h1,1,        32'h0,1,1,        32'hDE22BE44,0, 32'hDE22BE44,1);
    tbl[7]  = mk(1, 4'hF, 2,  32'h2,        32'h2,1,        32'h0,1,1,        32'hDE22BE44,0, 32'h1,1);
    tbl[8]  = mk(1, 4'hF, 3,  32'h3,        32'h3,1,        32'h0,1,1,        32'hDE22BE44,0, 32'h2,1);
    tbl[9]  = mk(1, 4'h0, 1,  32'h0,        32'h1,1,        32'h1,1,0,        32'h1,1,        32'h3,1);
    tbl[10] = mk(1, 4'h0, 2,  32'h0,        32'h2,1,        32'h2,1,0,        32'h2,1,        32'h1,1);
    tbl[11] = mk(1, 4'h0, 3,  32'h0,        32'h3,1,        32'h3,1,0,        32'h3,1,        32'h2,1);
    tbl[12] = mk(0, 4'h0, 3,  32'h0,        32'h3,0,        32'h3,0,0,        32'h3,0,        32'h3,1);
    tbl[13] = mk(0, 4'h0, 0,  32'h0,        32'h3,0,        32'h3,0,0,        32'h3,0,        32'h3,0);
    tbl[14] = mk(1, 4'hF, 21, 32'hAAAAAAAA, 32'h0,1,        32'h0,1,0,        32'h3,0,        32'h3,0);
    tbl[15] = mk(1, 4'h0, 21, 32'h0,        32'h0,1,        32'h0,1,0,        32'h0,1,        32'h0,1);
    tbl[16] = mk(1, 4'h0, 5,  32'h0,        32'hDE22BE44,1, 32'hDE22BE44,1,0, 32'hDE22BE44,1, 32'h0,1);
    tbl[17] = mk(1, 4'h8, 5,  32'h77000000, 32'h7722BE44,1, 32'hDE22BE44,1,0, 32'hDE22BE44,0, 32'hDE22BE44,1);
    tbl[18] = mk(1, 4'h0, 5,  32'h0,        32'h7722BE44,1, 32'h7722BE44,1,0, 32'h7722BE44,1, 32'h7722BE44,1);

    do_reset();

    for (int i = 0; i < 19; i++) begin
      en = tbl[i].en; we = tbl[i].we; addr = tbl[i].addr; di = tbl[i].di;
      step();
      chk($sformatf("row%0d_d0", i), d0, tbl[i].d0);
      chk($sformatf("row%0d_v0", i), {31'd0, v0}, {31'd0, tbl[i].v0});
      if (!tbl[i].dc1) chk($sformatf("row%0d_d1", i), d1, tbl[i].d1);
      chk($sformatf("row%0d_v1", i), {31'd0, v1}, {31'd0, tbl[i].v1});
      chk($sformatf("row%0d_d2", i), d2, tbl[i].d2);
      chk($sformatf("row%0d_v2", i), {31'd0, v2}, {31'd0, tbl[i].v2});
      chk($sformatf("row%0d_d3", i), d3, tbl[i].d3);
      chk($sformatf("row%0d_v3", i), {31'd0, v3}, {31'd0, tbl[i].v3});
    end

    // Reset lands on a write to @7 while valids are in flight in both stages.
    en = 1'b1; we = 4'hF; addr = 5'd7; di = 32'h12345678;
    step();
    chk("mid_wr_d0", d0, 32'h12345678);
    we = 4'h0;
    step();
    chk("mid_rd_d1", d1, 32'h12345678);
    chk("mid_rd_v3", {31'd0, v3}, 32'd1);
    rst = 1'b1; we = 4'hF; di = 32'hFFFFFFFF;
    step();
    chk("mid_rst_d", d0 | d1 | d2 | d3, 32'd0);
    chk("mid_rst_v", {28'd0, v0, v1, v2, v3}, 32'd0);
    rst = 1'b0; en = 1'b0; we = 4'h0;
    wait_idle();
    en = 1'b1;
    step();
`ifdef RAM_INIT_CLEAR_EN
    chk("mid_after_d0", d0, 32'h0);
`else
    chk("mid_after_d0", d0, 32'h12345678);
`endif
    chk("mid_after_v0", {31'd0, v0}, 32'd1);
    chk("mid_after_d3", d3, 32'd0);
    chk("mid_after_v3", {31'd0, v3}, 32'd0);
    en = 1'b0;
    step();
    chk("mid_lat2_v3", {31'd0, v3}, 32'd1);
    chk("mid_lat2_d3", d3, d0);

`ifdef RAM_INIT_CLEAR_EN
    // Writes during the sweep are dropped; a reset part-way restarts a full sweep.
    rst = 1'b1; en = 1'b0;
    step();
    rst = 1'b0; en = 1'b1; we = 4'hF; addr = 5'd3; di = 32'hFFFFFFFF;
    for (int c = 0; c < 8; c++) begin
      step();
      chk($sformatf("clr_busy%0d", c), {31'd0, b0}, 32'd1);
      chk($sformatf("clr_nov%0d", c), {31'd0, v0}, 32'd0);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_idle();
    en = 1'b1; we = 4'h0;
    for (int a = 0; a < DEPTH; a++) begin
      addr = 5'(a);
      step();
      chk($sformatf("clr_rd%0d", a), d0, 32'd0);
      chk($sformatf("clr_rv%0d", a), {31'd0, v0}, 32'd1);
    end
    en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
